logic_unit: RTL and testbench
=============================

# logic_unit

Parametrised, registered successor to the team's 1-bit gate primitives. Applies one of eight selectable bitwise logic functions to WIDTH-bit operands and returns the result through a valid/ready output register. In accumulate mode it folds a multi-beat packet into a single result. Sits between operand sources and downstream datapath consumers that need gate functions on buses with flow control.

## Interface
Parameters:
- WIDTH, 8, operand/result width in bits (≥1)

Ports:
- iClk  input  1  clock; all logic on rising edge
- iRsn  input  1  reset; synchronous, active-low
- iValid  input  1  input beat valid
- oReady  output  1  block can accept a beat this cycle
- iOp  input  3  function select, sampled per accepted beat
- iAcc  input  1  accumulate mode, sampled on first beat of a packet only
- iLast  input  1  last beat of packet (accumulate mode)
- iA  input  WIDTH  operand A
- iB  input  WIDTH  operand B
- oValid  output  1  result valid
- iReady  input  1  downstream accepts result
- oY  output  WIDTH  result
- oZero  output  1  oY == 0
- oParity  output  1  XOR-reduction of oY
- oBeats  output  8  beats in the packet that produced oY, saturating at 255

## Operation
- Function f(x,y) by iOp: 0 AND, 1 OR, 2 NOT (~x, y ignored), 3 NAND, 4 NOR, 5 XOR, 6 XNOR, 7 PASS (x).
- Accepted beat = iValid & oReady at a rising edge.
- oReady = (state != HOLD) | iReady. This is a combinational path from iReady; there is no path from iValid.
- FSM states: IDLE, ACC, HOLD.
- IDLE, or HOLD with iReady=1 (output drained same cycle), on an accepted beat:
  - iAcc=0, or iAcc=1 & iLast=1: oY ← f(iA,iB), oBeats ← 1, go HOLD.
  - iAcc=1 & iLast=0: acc ← f(iA,iB), cnt ← 1, go ACC.
  - No accepted beat: IDLE stays IDLE; HOLD with iReady=1 goes IDLE (oValid drops).
- ACC, on an accepted beat: acc' = f(acc, iA) with that beat's iOp; iB and iAcc ignored; cnt ← sat(cnt+1).
  - iLast=1: oY ← acc', oBeats ← sat(cnt+1), go HOLD.
  - Otherwise stay in ACC.
  - No beat: hold all state.
- HOLD: oValid=1. oY, oZero, oParity and oBeats are stable until the cycle iReady=1.
- oZero and oParity are registered together with oY, derived from the value being loaded.
- Saturation: cnt and oBeats stop at 255; packets longer than 255 beats still fold correctly.
- iLast is ignored when iAcc=0 outside ACC.

## Timing
- Reset values (iRsn=0 at a rising edge): state IDLE, oValid 0, oY 0, oZero 0, oParity 0, oBeats 0, acc 0, cnt 0.
- Reset overrides any beat presented in the same cycle. A reset in ACC or HOLD discards the partial or pending result.
- oReady=1 immediately after reset.
- Latency, single-beat: result is valid on the cycle after acceptance (1 cycle).
- Latency, N-beat packet: result is valid on the cycle after the iLast beat.
- Throughput: one beat per cycle while iReady=1, including back-to-back single-beat results with oValid held continuously high.
- Backpressure: with oValid=1 and iReady=0, oReady=0 and no beat is consumed.

## Test plan
- Reset and idle: hold iRsn=0 for 2 cycles with iValid=1 -> oValid=0, oY=0x00, oBeats=0, oReady=1 after release.
- All ops, single beat, iReady=1: iA=0xA5, iB=0x0F, iOp 0..7 back-to-back -> oY = 05, AF, 5A, FA, 50, AA, 55, A5 in order, one per cycle, 1-cycle latency. Check oZero=0 and parity matches each value.
- Accumulate, 3 beats:
  - Beat 1: iAcc=1, iOp=5, iA=0x0F, iB=0xF0.
  - Beat 2: iOp=0, iA=0x3C.
  - Beat 3: iOp=1, iA=0x01, iLast=1.
  - Required: oY=0x3D, oBeats=3 on the cycle after beat 3.
- Backpressure: result pending and iReady=0 for 4 cycles while iValid=1 -> oReady=0, oY held. On iReady=1, the next beat is accepted in that same cycle and its result appears the following cycle.
- Zero/parity flags: iOp=0, iA=0xF0, iB=0x0F -> oY=0x00, oZero=1, oParity=0. iOp=7, iA=0x07 -> oZero=0, oParity=1.
- Mid-packet reset and saturation:
  - Assert iRsn=0 during ACC after 2 beats -> next outputs IDLE values, no result emitted.
  - Separate run of 300-beat packet, iOp=1, iA=1 << (k mod 8) -> oY=0xFF, oBeats=255.

Source files
------------

// File: rtl/logic_unit.sv
// Registered WIDTH-bit logic unit: one of eight bitwise functions per beat, with an
// optional accumulate mode that folds a multi-beat packet into one valid/ready result.
//
//   state | meaning
//   ------+---------------------------------------------------------------
//   IDLE  | no result pending, no packet in progress
//   ACC   | accumulate packet in progress; acc_q holds the running fold
//   HOLD  | result on oY/oZero/oParity/oBeats, oValid high until iReady
module logic_unit #(
    parameter int WIDTH = 8
) (
    input  logic             iClk,
    input  logic             iRsn,
    input  logic             iValid,
    output logic             oReady,
    input  logic [2:0]       iOp,
    input  logic             iAcc,
    input  logic             iLast,
    input  logic [WIDTH-1:0] iA,
    input  logic [WIDTH-1:0] iB,
    output logic             oValid,
    input  logic             iReady,
    output logic [WIDTH-1:0] oY,
    output logic             oZero,
    output logic             oParity,
    output logic [7:0]       oBeats
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        HOLD = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   acc_q, acc_d;
    logic [7:0]         cnt_q, cnt_d;
    logic [WIDTH-1:0]   y_q, y_d;
    logic               zero_q, zero_d;
    logic               parity_q, parity_d;
    logic [7:0]         beats_q, beats_d;
    logic               accept;
    logic [WIDTH-1:0]   beat_res;
    logic [7:0]         cnt_inc;

    function automatic logic [WIDTH-1:0] logic_fn(input logic [2:0] op,
                                                  input logic [WIDTH-1:0] x,
                                                  input logic [WIDTH-1:0] y);
        logic [WIDTH-1:0] r;
        case (op)
            3'd0:    r = x & y;
            3'd1:    r = x | y;
            3'd2:    r = ~x;
            3'd3:    r = ~(x & y);
            3'd4:    r = ~(x | y);
            3'd5:    r = x ^ y;
            3'd6:    r = ~(x ^ y);
            default: r = x;
        endcase
        return r;
    endfunction

    // Draining the held result frees the register for a new beat in the same cycle.
    assign oReady = (state_q != HOLD) | iReady;
    assign accept = iValid & oReady;
    assign cnt_inc = (cnt_q == 8'hFF) ? 8'hFF : cnt_q + 8'd1;

    // In ACC the running value replaces operand A and iA takes the place of operand B.
    assign beat_res = (state_q == ACC) ? logic_fn(iOp, acc_q, iA)
                                       : logic_fn(iOp, iA, iB);

    always_comb begin
        state_d  = state_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        y_d      = y_q;
        zero_d   = zero_q;
        parity_d = parity_q;
        beats_d  = beats_q;
        case (state_q)
            ACC: begin
                if (accept) begin
                    acc_d = beat_res;
                    cnt_d = cnt_inc;
                    if (iLast) begin
                        y_d      = beat_res;
                        zero_d   = (beat_res == '0);
                        parity_d = ^beat_res;
                        beats_d  = cnt_inc;
                        state_d  = HOLD;
                    end
                end
            end
            default: begin
                if (accept) begin
                    if (!iAcc || iLast) begin
                        y_d      = beat_res;
                        zero_d   = (beat_res == '0);
                        parity_d = ^beat_res;
                        beats_d  = 8'd1;
                        state_d  = HOLD;
                    end else begin
                        acc_d   = beat_res;
                        cnt_d   = 8'd1;
                        state_d = ACC;
                    end
                end else if (state_q == HOLD && iReady) begin
                    state_d = IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge iClk) begin
        if (!iRsn) begin
            state_q  <= IDLE;
            acc_q    <= '0;
            cnt_q    <= 8'd0;
            y_q      <= '0;
            zero_q   <= 1'b0;
            parity_q <= 1'b0;
            beats_q  <= 8'd0;
        end else begin
            state_q  <= state_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            y_q      <= y_d;
            zero_q   <= zero_d;
            parity_q <= parity_d;
            beats_q  <= beats_d;
        end
    end

    assign oValid  = (state_q == HOLD);
    assign oY      = y_q;
    assign oZero   = zero_q;
    assign oParity = parity_q;
    assign oBeats  = beats_q;

endmodule

// File: tb/tb_logic_unit.sv
// Directed bench for logic_unit: reset, all functions, accumulate packets,
// backpressure, flags, mid-packet reset and beat-count saturation.
module tb_logic_unit;

    logic       iClk;
    logic       iRsn;
    logic       iValid;
    logic       oReady;
    logic [2:0] iOp;
    logic       iAcc;
    logic       iLast;
    logic [7:0] iA;
    logic [7:0] iB;
    logic       oValid;
    logic       iReady;
    logic [7:0] oY;
    logic       oZero;
    logic       oParity;
    logic [7:0] oBeats;

    int n_tests = 0;
    int n_fail  = 0;

    logic [7:0] op_exp [8] = '{8'h05, 8'hAF, 8'h5A, 8'hFA, 8'h50, 8'hAA, 8'h55, 8'hA5};

    logic_unit #(.WIDTH(8)) dut (
        .iClk    (iClk),
        .iRsn    (iRsn),
        .iValid  (iValid),
        .oReady  (oReady),
        .iOp     (iOp),
        .iAcc    (iAcc),
        .iLast   (iLast),
        .iA      (iA),
        .iB      (iB),
        .oValid  (oValid),
        .iReady  (iReady),
        .oY      (oY),
        .oZero   (oZero),
        .oParity (oParity),
        .oBeats  (oBeats)
    );

    initial iClk = 1'b0;
    always #5 iClk = ~iClk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge and settle so outputs are sampled away from the edge.
    task automatic step();
        @(posedge iClk);
        #1;
    endtask

    initial begin
        iRsn = 1'b0; iValid = 1'b1; iOp = 3'd7; iAcc = 1'b0; iLast = 1'b0;
        iA = 8'hFF; iB = 8'h00; iReady = 1'b1;
        step();
        step();
        chk("rst_valid", 32'(oValid), 32'd0);
        chk("rst_y", 32'(oY), 32'h00);
        chk("rst_beats", 32'(oBeats), 32'd0);
        chk("rst_zero", 32'(oZero), 32'd0);
        chk("rst_parity", 32'(oParity), 32'd0);
        iRsn = 1'b1; iValid = 1'b0;
        #1;
        chk("rst_ready", 32'(oReady), 32'd1);

        // all functions back-to-back, A5 op 0F
        iValid = 1'b1; iA = 8'hA5; iB = 8'h0F;
        for (int op = 0; op < 8; op++) begin
            iOp = 3'(op);
            step();
            chk($sformatf("op%0d_valid", op), 32'(oValid), 32'd1);
            chk($sformatf("op%0d_y", op), 32'(oY), 32'(op_exp[op]));
            chk($sformatf("op%0d_zero", op), 32'(oZero), 32'd0);
            chk($sformatf("op%0d_parity", op), 32'(oParity), 32'd0);
            chk($sformatf("op%0d_beats", op), 32'(oBeats), 32'd1);
        end
        iValid = 1'b0;
        step();
        chk("drain_valid", 32'(oValid), 32'd0);

        // 3-beat accumulate: (0F^F0)=FF, &3C=3C, |01=3D
        iValid = 1'b1; iAcc = 1'b1; iOp = 3'd5; iA = 8'h0F; iB = 8'hF0; iLast = 1'b0;
        step();
        chk("acc1_valid", 32'(oValid), 32'd0);
        iAcc = 1'b0; iOp = 3'd0; iA = 8'h3C; iB = 8'hFF;
        step();
        chk("acc2_valid", 32'(oValid), 32'd0);
        iOp = 3'd1; iA = 8'h01; iLast = 1'b1;
        step();
        chk("acc_valid", 32'(oValid), 32'd1);
        chk("acc_y", 32'(oY), 32'h3D);
        chk("acc_beats", 32'(oBeats), 32'd3);
        chk("acc_parity", 32'(oParity), 32'd1);

        // backpressure on the pending 3D, with a zero-result beat waiting
        iReady = 1'b0; iLast = 1'b0; iOp = 3'd0; iA = 8'hF0; iB = 8'h0F;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("bp_ready", 32'(oReady), 32'd0);
            chk("bp_y", 32'(oY), 32'h3D);
            chk("bp_valid", 32'(oValid), 32'd1);
        end
        iReady = 1'b1;
        #1;
        chk("bp_release_ready", 32'(oReady), 32'd1);
        step();
        chk("zero_y", 32'(oY), 32'h00);
        chk("zero_flag", 32'(oZero), 32'd1);
        chk("zero_parity", 32'(oParity), 32'd0);
        chk("zero_beats", 32'(oBeats), 32'd1);
        chk("zero_valid", 32'(oValid), 32'd1);
        iOp = 3'd7; iA = 8'h07;
        step();
        chk("pass_y", 32'(oY), 32'h07);
        chk("pass_zero", 32'(oZero), 32'd0);
        chk("pass_parity", 32'(oParity), 32'd1);
        iValid = 1'b0;
        step();
        chk("idle_valid", 32'(oValid), 32'd0);

        // reset after two beats of an accumulate packet
        iValid = 1'b1; iAcc = 1'b1; iLast = 1'b0; iOp = 3'd1; iA = 8'h01; iB = 8'h02;
        step();
        iAcc = 1'b0;
        step();
        iRsn = 1'b0;
        step();
        chk("mrst_valid", 32'(oValid), 32'd0);
        chk("mrst_y", 32'(oY), 32'h00);
        chk("mrst_beats", 32'(oBeats), 32'd0);
        chk("mrst_ready", 32'(oReady), 32'd1);
        iRsn = 1'b1; iValid = 1'b0;
        step();
        step();
        chk("mrst_no_result", 32'(oValid), 32'd0);
        // a lone last beat after the reset must be a fresh single-beat result
        iValid = 1'b1; iAcc = 1'b0; iLast = 1'b1; iOp = 3'd7; iA = 8'h40;
        step();
        chk("mrst_fresh_y", 32'(oY), 32'h40);
        chk("mrst_fresh_beats", 32'(oBeats), 32'd1);
        iValid = 1'b0; iLast = 1'b0;
        step();

        // 300-beat OR packet walking a one through every bit
        for (int k = 0; k < 300; k++) begin
            iValid = 1'b1;
            iAcc   = (k == 0);
            iLast  = (k == 299);
            iOp    = 3'd1;
            iA     = 8'(1 << (k % 8));
            iB     = 8'h00;
            step();
            if (k == 150) chk("sat_mid_valid", 32'(oValid), 32'd0);
        end
        chk("sat_valid", 32'(oValid), 32'd1);
        chk("sat_y", 32'(oY), 32'hFF);
        chk("sat_beats", 32'(oBeats), 32'd255);
        chk("sat_parity", 32'(oParity), 32'd0);
        iValid = 1'b0; iLast = 1'b0;
        step();
        chk("sat_drain", 32'(oValid), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
